ram32k_host_arbiter: RTL and testbench

// - Single-clock arbiter sharing the 32 KB embedded RAM (0x0000-0x7FFF) between the 6502 CPU and a byte-wide host loader port (HEX/BIN download, readback).
// - Replaces the emu_en/emu_clk mux: the host never switches the RAM clock. It requests one byte; the arbiter stalls the CPU via RDY, runs the host access, restores the CPU address and acknowledges.
// - Sits between cpu_6502 / RAM32k and the host bridge in the Apple-I top level.

---
 rtl/ram32k_host_arbiter_pkg.sv | 23 ++
 rtl/ram32k_host_arbiter.sv | 150 +++++++++++++++
 tb/tb_ram32k_host_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram32k_host_arbiter_pkg.sv
// ram32k_host_arbiter_pkg
//   Shared definitions for the 32 KB RAM host/CPU arbiter: FSM state codes
//   and the address bit that selects the RAM region on the 6502 bus.
package ram32k_host_arbiter_pkg;

  // FSM state codes (3-bit encoding kept stable for debug visibility)
  typedef enum logic [2:0] {
    ARB_IDLE = 3'd0,
    ARB_HOLD = 3'd1,
    ARB_HOST = 3'd2,
    ARB_CAPT = 3'd3,
    ARB_ACK  = 3'd4
  } arb_state_e;

  // AB[15]==0 selects the embedded RAM on the 6502 bus
  localparam int RAM_REGION_BIT = 15;

  // Helper for the top level that derives cpu_sel from the full CPU address
  function automatic logic in_ram_region(input logic [15:0] ab);
    return ~ab[RAM_REGION_BIT];
  endfunction

endpackage

// File: rtl/ram32k_host_arbiter.sv
// ram32k_host_arbiter
//   Shares the 32 KB embedded RAM between the 6502 CPU and a byte-wide host
//   loader port. The RAM clock is never switched: a host request stalls the
//   CPU through RDY, performs one host byte access, puts the CPU address back
//   on the RAM and then raises a level acknowledge (4-phase handshake).
//
//   Ports
//     clk, reset          system clock, synchronous active-high reset
//     rdy_in              external RDY request, ANDed into cpu_rdy
//     cpu_rdy             RDY to the CPU
//     cpu_addr/sel/we/do  CPU RAM-side bus (sel = address in RAM region)
//     ram_addr/we/din     RAM write/address port
//     ram_dout            RAM read data, valid RD_LAT cycles after address
//     host_req/we/addr/di host request (level, held until host_ack)
//     host_hold           bulk mode: keep the CPU stalled between requests
//     host_ack, host_do   level acknowledge and read data (valid with ack)
//
//   Timing (req sampled at edge N): stall_q is high for 2+RD_LAT cycles
//   (HOLD, HOST, RD_LAT x CAPT); host_ack rises on the same edge stall_q
//   falls.
module ram32k_host_arbiter
  import ram32k_host_arbiter_pkg::*;
#(
  parameter int AW     = 15,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rdy_in,
  output logic          cpu_rdy,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_sel,
  input  logic          cpu_we,
  input  logic [DW-1:0] cpu_do,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_di,
  input  logic          host_hold,
  output logic          host_ack,
  output logic [DW-1:0] host_do
);

  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;
  localparam logic [LW-1:0] LAT_LOAD = LW'(RD_LAT - 1);

  arb_state_e    state, state_nxt;
  logic          stall_q;
  logic [LW-1:0] lat_cnt;
  logic [AW-1:0] host_addr_q;
  logic          host_we_q;
  logic [DW-1:0] host_di_q;
  logic          cpu_rdy_c;
  logic          capt_done;

  assign capt_done = (lat_cnt == '0);

  // ------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state <= ARB_IDLE;
    else       state <= state_nxt;
  end

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB_IDLE: if (host_req) state_nxt = ARB_HOLD;
      // one quiet cycle: CPU is already stalled, nothing is written
      ARB_HOLD: state_nxt = ARB_HOST;
      ARB_HOST: state_nxt = ARB_CAPT;
      // a host_req drop here is ignored: the access always completes
      ARB_CAPT: if (capt_done) state_nxt = ARB_ACK;
      // while acked, a still-high req is not a new request
      ARB_ACK:  if (!host_req) state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // Output logic: RAM mux and CPU RDY
  // ------------------------------------------------------------------
  // host_hold acts combinationally so a bulk loader can freeze the CPU
  // without waiting for the FSM.
  assign cpu_rdy_c = rdy_in & ~stall_q & ~host_hold;
  assign cpu_rdy   = cpu_rdy_c;

  always_comb begin
    ram_addr = cpu_addr;
    ram_din  = cpu_do;
    ram_we   = cpu_we & cpu_sel & cpu_rdy_c;
    if (state == ARB_HOST) begin
      ram_addr = host_addr_q;
      ram_din  = host_di_q;
      ram_we   = host_we_q;
    end
    // a write coinciding with reset must not reach the RAM
    if (reset) ram_we = 1'b0;
  end

  // ------------------------------------------------------------------
  // Datapath registers: request latch, stall, latency counter, ack/data
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q     <= 1'b0;
      host_ack    <= 1'b0;
      host_do     <= '0;
      lat_cnt     <= '0;
      host_addr_q <= '0;
      host_we_q   <= 1'b0;
      host_di_q   <= '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (host_req) begin
            host_addr_q <= host_addr;
            host_we_q   <= host_we;
            host_di_q   <= host_di;
            stall_q     <= 1'b1;
          end
        end
        ARB_HOST: lat_cnt <= LAT_LOAD;
        ARB_CAPT: begin
          // the CPU address is back on the RAM during CAPT, so by the time
          // stall_q drops the RAM output is CPU data again
          if (capt_done) begin
            if (!host_we_q) host_do <= ram_dout;
            stall_q  <= 1'b0;
            host_ack <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        ARB_ACK: if (!host_req) host_ack <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram32k_host_arbiter.sv
module tb_ram32k_host_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        rdy_in;
  logic        cpu_rdy;
  logic [14:0] cpu_addr;
  logic        cpu_sel;
  logic        cpu_we;
  logic [7:0]  cpu_do;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic        host_req;
  logic        host_we;
  logic [14:0] host_addr;
  logic [7:0]  host_di;
  logic        host_hold;
  logic        host_ack;
  logic [7:0]  host_do;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ram32k_host_arbiter #(.AW(15), .DW(8), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset), .rdy_in(rdy_in), .cpu_rdy(cpu_rdy),
    .cpu_addr(cpu_addr), .cpu_sel(cpu_sel), .cpu_we(cpu_we), .cpu_do(cpu_do),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_di(host_di), .host_hold(host_hold), .host_ack(host_ack),
    .host_do(host_do)
  );

  // synchronous RAM, read latency 1
  logic [7:0] mem [0:32767];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // One host byte transfer; called and returning at a negedge.
  task automatic xfer(input bit we, input logic [14:0] a, input logic [7:0] d,
                      input int drop_at, input int linger,
                      output logic [7:0] rd, output logic [7:0] dout_ack,
                      output int ack_n, output int stall_n,
                      output int wr_n, output int bad_n);
    ack_n = 0; stall_n = 0; wr_n = 0; bad_n = 0; rd = '0; dout_ack = '0;
    host_we = we; host_addr = a; host_di = d; host_req = 1'b1;
    for (int n = 1; n <= 20 && ack_n == 0; n++) begin
      @(posedge clk); @(negedge clk);
      if (!cpu_rdy) stall_n++;
      if (ram_we) begin
        if (ram_addr == a && ram_din == d) wr_n++;
        else bad_n++;
      end
      if (host_ack) begin
        ack_n = n; rd = host_do; dout_ack = ram_dout;
      end
      if (n == drop_at) host_req = 1'b0;
    end
    for (int k = 0; k < linger; k++) begin
      @(posedge clk); @(negedge clk);
      chk("ack_linger", host_ack, 1);
      chk("rdy_linger", cpu_rdy, 1);
    end
    host_req = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("ack_drop", host_ack, 0);
  endtask

  typedef struct {
    bit          we;
    logic [14:0] addr;
    logic [7:0]  di;
    logic [7:0]  exp_do;
    int          drop_at;
    int          linger;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [7:0] rd, dack;
    int ack_n, stall_n, wr_n, bad_n;
    int s_ack, s_stall, s_wr, s_bad, s_miss, s_idle_rdy;
    int cpu_wr, stalled_wr;
    logic [7:0] pat;

    tbl[0]  = '{1'b1, 15'h0200, 8'h11, 8'h00, 0, 0};
    tbl[1]  = '{1'b1, 15'h0300, 8'h5A, 8'h00, 0, 0};
    tbl[2]  = '{1'b0, 15'h0300, 8'h00, 8'h5A, 0, 2};
    tbl[3]  = '{1'b1, 15'h7FFF, 8'hC3, 8'h5A, 0, 0};
    tbl[4]  = '{1'b0, 15'h7FFF, 8'h00, 8'hC3, 0, 0};
    tbl[5]  = '{1'b1, 15'h0201, 8'h22, 8'hC3, 0, 0};
    tbl[6]  = '{1'b0, 15'h0201, 8'h00, 8'h22, 0, 0};
    tbl[7]  = '{1'b0, 15'h0200, 8'h00, 8'h11, 0, 0};
    tbl[8]  = '{1'b1, 15'h0000, 8'hA5, 8'h11, 0, 0};
    tbl[9]  = '{1'b0, 15'h0000, 8'h00, 8'hA5, 1, 0};
    tbl[10] = '{1'b0, 15'h7FFF, 8'h00, 8'hC3, 2, 0};
    tbl[11] = '{1'b1, 15'h0010, 8'h42, 8'hC3, 3, 0};

    // reset with a CPU write pending: nothing may reach the RAM
    reset = 1'b1; rdy_in = 1'b1; host_hold = 1'b0;
    cpu_addr = 15'h0200; cpu_sel = 1'b1; cpu_we = 1'b1; cpu_do = 8'hEE;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_di = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ack", host_ack, 0);
    chk("rst_do", host_do, 0);
    chk("rst_rdy", cpu_rdy, 1);
    reset = 1'b0; cpu_we = 1'b0;

    // cpu_rdy / CPU write gating
    cpu_addr = 15'h0500; cpu_do = 8'h66; cpu_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rdy_in = i[0]; host_hold = i[1]; #1;
      chk("comb_rdy", cpu_rdy, i[0] & ~i[1]);
      chk("comb_we", ram_we, i[0] & ~i[1]);
    end
    rdy_in = 1'b1; host_hold = 1'b0; cpu_sel = 1'b0; #1;
    chk("comb_sel_we", ram_we, 0);
    chk("comb_addr", ram_addr, 15'h0500);
    cpu_sel = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0200;
    @(negedge clk);

    // table: CPU keeps reading 0x0200 (LDA loop) while the host works
    foreach (tbl[i]) begin
      xfer(tbl[i].we, tbl[i].addr, tbl[i].di, tbl[i].drop_at, tbl[i].linger,
           rd, dack, ack_n, stall_n, wr_n, bad_n);
      chk($sformatf("v%0d_ack_n", i), ack_n, 4);
      chk($sformatf("v%0d_stall", i), stall_n, 3);
      chk($sformatf("v%0d_wr", i), wr_n, tbl[i].we ? 1 : 0);
      chk($sformatf("v%0d_badwr", i), bad_n, 0);
      chk($sformatf("v%0d_do", i), rd, tbl[i].exp_do);
      chk($sformatf("v%0d_cpu_dout", i), dack, 8'h11);
    end
    chk("mem_0300", mem[15'h0300], 8'h5A);
    chk("mem_0201", mem[15'h0201], 8'h22);

    // CPU STA $0400 stalled by a host read of the same byte
    xfer(1'b1, 15'h0400, 8'h99, 0, 0, rd, dack, ack_n, stall_n, wr_n, bad_n);
    host_we = 1'b0; host_addr = 15'h0400; host_req = 1'b1;
    cpu_wr = 0; stalled_wr = 0; ack_n = 0; rd = '0;
    for (int n = 1; n <= 20 && ack_n == 0; n++) begin
      @(posedge clk); @(negedge clk);
      if (n == 1) begin
        cpu_addr = 15'h0400; cpu_do = 8'h77; cpu_we = 1'b1; #1;
      end
      if (ram_we && !cpu_rdy) stalled_wr++;
      if (ram_we && cpu_rdy) cpu_wr++;
      if (host_ack) begin ack_n = n; rd = host_do; end
    end
    host_req = 1'b0;
    @(posedge clk); @(negedge clk);
    cpu_we = 1'b0; cpu_addr = 15'h0200;
    chk("sta_ack_n", ack_n, 4);
    chk("sta_host_do", rd, 8'h99);
    chk("sta_no_stalled_wr", stalled_wr, 0);
    chk("sta_cpu_wr", cpu_wr, 1);
    chk("sta_mem", mem[15'h0400], 8'h77);

    // bulk burst with host_hold: CPU frozen throughout
    host_hold = 1'b1; #1;
    chk("hold_rdy", cpu_rdy, 0);
    s_ack = 0; s_stall = 0; s_wr = 0; s_bad = 0; s_miss = 0; s_idle_rdy = 0;
    for (int i = 0; i < 512; i++) begin
      pat = 8'(i) ^ 8'hA5;
      xfer(i < 256, 15'h0280 + 15'(i % 256), pat, 0, 0,
           rd, dack, ack_n, stall_n, wr_n, bad_n);
      s_ack += ack_n; s_stall += stall_n; s_wr += wr_n; s_bad += bad_n;
      if (i >= 256 && rd != pat) s_miss++;
      if (cpu_rdy) s_idle_rdy++;
    end
    chk("burst_ack_sum", s_ack, 512 * 4);
    chk("burst_stall_sum", s_stall, 512 * 4);
    chk("burst_wr_sum", s_wr, 256);
    chk("burst_badwr", s_bad, 0);
    chk("burst_readback_miss", s_miss, 0);
    chk("burst_idle_rdy", s_idle_rdy, 0);
    host_hold = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("hold_release_rdy", cpu_rdy, 1);

    // reset while in HOST with a write of 0xFF to 0x0010
    host_we = 1'b1; host_addr = 15'h0010; host_di = 8'hFF; host_req = 1'b1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("host_ram_we_before_rst", ram_we, 1);
    reset = 1'b1; #1;
    chk("rst_host_we", ram_we, 0);
    host_req = 1'b0;
    @(posedge clk); @(negedge clk);
    reset = 1'b0; #1;
    chk("rst_mid_ack", host_ack, 0);
    chk("rst_mid_rdy", cpu_rdy, 1);
    chk("rst_mid_mem", mem[15'h0010], 8'h42);
    rdy_in = 1'b0; #1;
    chk("rst_mid_rdy_in", cpu_rdy, 0);
    rdy_in = 1'b1;
    xfer(1'b0, 15'h0010, 8'h00, 0, 0, rd, dack, ack_n, stall_n, wr_n, bad_n);
    chk("post_rst_ack_n", ack_n, 4);
    chk("post_rst_do", rd, 8'h42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
